jtag_dtm_ctrl: RTL and testbench
================================

JTAG_DTM_CTRL -- requirements
Module: jtag_dtm_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7: DMI address width.
REQ-002 SHALL have parameter DR_WIDTH, default 41: custom-register data width; SHALL be at least ABITS+34.
REQ-003 SHALL have parameter IDLE_HINT, default 3'd1: value reported in dtmcs.idle.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: tck_i and trst_n_i.
REQ-005 SHALL have the following ports:
- tck_i  in  1  JTAG clock; the only clock.
- trst_n_i  in  1  asynchronous active-low reset.
- cust_rg_addr_i  in  1  custom register index: 0=dtmcs, 1=dmi.
- cust_rg_val_i  in  1  custom register selected.
- cust_rg_dat_i  in  DR_WIDTH  shifted value from the TAP.
- cust_rg_dat_o  out  DR_WIDTH  capture value to the TAP.
- cust_rg_dat_re_i  in  1  Capture-DR strobe.
- cust_rg_dat_we_i  in  1  Update-DR strobe.
- dmi_req_valid_o / dmi_req_ready_i  out/in  1  request handshake.
- dmi_req_addr_o  out  ABITS  request address.
- dmi_req_data_o  out  32  request data.
- dmi_req_op_o  out  2  request op: 1=read, 2=write.
- dmi_resp_valid_i / dmi_resp_ready_o  in/out  1  response handshake.
- dmi_resp_data_i  in  32  response data.
- dmi_resp_op_i  in  2  response status: 0=ok, 2=fail, 3=busy.
- dmi_hard_reset_o  out  1  one-cycle reset pulse to the debug module.

Function
REQ-006 SHALL implement FSM states IDLE, REQ and WAIT.
- IDLE->REQ: on an accepted dmi write.
- REQ->WAIT: when dmi_req_valid_o and dmi_req_ready_i are both 1.
- WAIT->IDLE: when dmi_resp_valid_i is 1.
REQ-007 An accepted dmi write SHALL satisfy: cust_rg_dat_we_i=1, cust_rg_val_i=1, addr=1, state=IDLE, sticky=0, and op field (bits[1:0]) equal to 1 or 2; op 0 or 3 SHALL do nothing.
REQ-008 On acceptance SHALL latch addr=dat[ABITS+33:34], data=dat[33:2], op=dat[1:0]; dmi_req_valid_o SHALL be 1 in the next cycle.
REQ-009 dmi_req_valid_o SHALL be 1 only in REQ; request fields SHALL stay stable while it is 1.
REQ-010 dmi_resp_ready_o SHALL be 1 only in WAIT.
REQ-011 On the response cycle SHALL latch resp_data=dmi_resp_data_i; if dmi_resp_op_i is nonzero and sticky=0, SHALL set sticky=dmi_resp_op_i.
REQ-012 A dmi write while state is not IDLE SHALL be ignored and SHALL set sticky=3 if sticky=0.
REQ-013 cust_rg_dat_o SHALL be combinational, selected by cust_rg_addr_i, and zero-extended to DR_WIDTH:
- addr 0 (dtmcs): {14'b0, 2'b00, 1'b0, IDLE_HINT, sticky[1:0], ABITS[5:0], 4'd1}.
- addr 1 (dmi): {latched addr, resp_data, op}, where op=3 if state is not IDLE, otherwise sticky.
REQ-014 A dmi capture (cust_rg_dat_re_i=1, addr=1) while state is not IDLE SHALL set sticky=3 if sticky=0.
REQ-015 A dtmcs write with bit16 (dmireset)=1 SHALL clear sticky; FSM state SHALL be unaffected.
REQ-016 If a sticky-set event and dmireset occur in the same cycle, the clear SHALL win.
REQ-017 Writes with cust_rg_val_i=0 SHALL be ignored.
REQ-018 dtmcs writes SHALL change no fields other than those defined in REQ-015 and REQ-023.

Reset
REQ-019 On trst_n_i=0 SHALL immediately force:
- state=IDLE, sticky=0.
- latched addr/data/op/resp_data=0.
- dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_hard_reset_o=0.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction; no response SHALL be awaited afterwards.
REQ-021 After reset release, the first accepted write SHALL behave as from cold start.

Configuration
REQ-022 SHALL support macro JTAG_DTM_HARDRESET_EN.
REQ-023 With JTAG_DTM_HARDRESET_EN defined, a dtmcs write with bit17=1 SHALL, in the next cycle:
- pulse dmi_hard_reset_o for exactly one cycle.
- force state=IDLE and clear sticky.
- drop dmi_req_valid_o and dmi_resp_ready_o.
REQ-024 Without JTAG_DTM_HARDRESET_EN, bit17 SHALL be ignored and dmi_hard_reset_o SHALL be tied 0.

Structure
REQ-025 Package dtm_pkg SHALL hold:
- DMI op encodings (NOP/READ/WRITE, OK/FAIL/BUSY).
- the FSM state typedef.
- dtmcs field bit positions and DTM version 4'd1.
REQ-026 The block SHALL be a single module with no sub-module.

Verification
REQ-027 Write dmi {addr 7'h10, data 32'hDEADBEEF, op 2} -> next cycle req_valid=1, addr 7'h10, data DEADBEEF, op 2; ready=1 -> WAIT; resp op 0 -> IDLE, sticky 0.
REQ-028 Read op 1 to addr 7'h11, resp data 32'h12345678 op 0 -> dmi capture returns {7'h11, 32'h12345678, 2'd0}.
REQ-029 Capture dmi while in WAIT -> op field 3, sticky=3, dtmcs bits[11:10]=3; next dmi write ignored; dtmcs write 32'h0001_0000 -> sticky 0, next write accepted.
REQ-030 Response with op 2 -> sticky 2; subsequent writes ignored until dmireset.
REQ-031 trst_n_i low in REQ with req_valid=1 -> req_valid 0 immediately; capture dtmcs returns 32'h0000_1071 (zero-extended, defaults).
REQ-032 With JTAG_DTM_HARDRESET_EN, dtmcs write bit17 in WAIT -> one-cycle dmi_hard_reset_o, state IDLE, resp_ready 0.

Source files
------------

// File: rtl/dtm_pkg.sv
// dtm_pkg: shared DMI op encodings, DTM FSM state type and dtmcs field positions
package dtm_pkg;
  localparam logic [1:0] DMI_NOP   = 2'd0;
  localparam logic [1:0] DMI_READ  = 2'd1;
  localparam logic [1:0] DMI_WRITE = 2'd2;
  localparam logic [1:0] DMI_OK    = 2'd0;
  localparam logic [1:0] DMI_FAIL  = 2'd2;
  localparam logic [1:0] DMI_BUSY  = 2'd3;
  localparam int DTMCS_VERSION_LSB = 0;
  localparam int DTMCS_ABITS_LSB   = 4;
  localparam int DTMCS_DMISTAT_LSB = 10;
  localparam int DTMCS_IDLE_LSB    = 12;
  localparam int DTMCS_DMIRESET    = 16;
  localparam int DTMCS_HARDRESET   = 17;
  localparam logic [3:0] DTM_VERSION = 4'd1;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} dtm_state_e;
endpackage

// File: rtl/jtag_dtm_ctrl.sv
// jtag_dtm_ctrl: RISC-V debug transport module, turns dtmcs/dmi DR accesses into DMI transactions
// Ports: tck_i/trst_n_i clock and async active-low reset; cust_rg_* TAP custom register
// access (addr 0=dtmcs, 1=dmi, capture/update strobes); dmi_req_*/dmi_resp_* DMI handshakes;
// dmi_hard_reset_o one-cycle debug module reset, only driven when JTAG_DTM_HARDRESET_EN is defined.
module jtag_dtm_ctrl
  import dtm_pkg::*;
#(
  parameter int ABITS = 7,
  parameter int DR_WIDTH = 41,
  parameter logic [2:0] IDLE_HINT = 3'd1
) (
  input  logic                tck_i,
  input  logic                trst_n_i,
  input  logic                cust_rg_addr_i,
  input  logic                cust_rg_val_i,
  input  logic [DR_WIDTH-1:0] cust_rg_dat_i,
  output logic [DR_WIDTH-1:0] cust_rg_dat_o,
  input  logic                cust_rg_dat_re_i,
  input  logic                cust_rg_dat_we_i,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  output logic [ABITS-1:0]    dmi_req_addr_o,
  output logic [31:0]         dmi_req_data_o,
  output logic [1:0]          dmi_req_op_o,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o,
  input  logic [31:0]         dmi_resp_data_i,
  input  logic [1:0]          dmi_resp_op_i,
  output logic                dmi_hard_reset_o
);
  localparam logic [5:0] ABITS6 = 6'(ABITS);
  dtm_state_e state, state_nxt;
  logic [1:0] sticky, sticky_nxt, wr_op, op_out;
  logic [ABITS-1:0] addr_q;
  logic [31:0] data_q, resp_q;
  logic [1:0] op_q;
  logic dmi_wr, dtmcs_wr, accept, busy_evt, resp_evt, hard_evt, clr;
  logic [31:0] dtmcs;
  logic unused_bits;
  assign unused_bits = ^cust_rg_dat_i;
  assign wr_op = cust_rg_dat_i[1:0];
  assign dmi_wr = cust_rg_dat_we_i & cust_rg_val_i & cust_rg_addr_i;
  assign dtmcs_wr = cust_rg_dat_we_i & cust_rg_val_i & ~cust_rg_addr_i;
  assign accept = dmi_wr && state == ST_IDLE && sticky == DMI_OK && (wr_op == DMI_READ || wr_op == DMI_WRITE);
  // Touching dmi while a transaction is outstanding is a host overrun and latches busy.
  assign busy_evt = state != ST_IDLE && (dmi_wr || (cust_rg_dat_re_i && cust_rg_addr_i));
  assign resp_evt = state == ST_WAIT && dmi_resp_valid_i;
`ifdef JTAG_DTM_HARDRESET_EN
  logic hard_q;
  assign hard_evt = dtmcs_wr & cust_rg_dat_i[DTMCS_HARDRESET];
  assign dmi_hard_reset_o = hard_q;
  always_ff @(posedge tck_i or negedge trst_n_i)
    if (!trst_n_i) hard_q <= 1'b0;
    else hard_q <= hard_evt;
`else
  assign hard_evt = 1'b0;
  assign dmi_hard_reset_o = 1'b0;
`endif
  // Clearing takes priority over any error raised in the same cycle.
  assign clr = (dtmcs_wr & cust_rg_dat_i[DTMCS_DMIRESET]) | hard_evt;
  always_comb begin
    state_nxt = hard_evt ? ST_IDLE :
                accept ? ST_REQ :
                (state == ST_REQ && dmi_req_ready_i) ? ST_WAIT :
                resp_evt ? ST_IDLE : state;
    sticky_nxt = clr ? DMI_OK :
                 sticky != DMI_OK ? sticky :
                 busy_evt ? DMI_BUSY :
                 (resp_evt && dmi_resp_op_i != DMI_OK) ? dmi_resp_op_i : sticky;
  end
  always_ff @(posedge tck_i or negedge trst_n_i)
    if (!trst_n_i) state <= ST_IDLE;
    else state <= state_nxt;
  always_ff @(posedge tck_i or negedge trst_n_i)
    if (!trst_n_i) begin
      sticky <= DMI_OK;
      addr_q <= '0;
      data_q <= '0;
      op_q <= DMI_NOP;
      resp_q <= '0;
    end else begin
      sticky <= sticky_nxt;
      if (accept) begin
        addr_q <= cust_rg_dat_i[ABITS+33:34];
        data_q <= cust_rg_dat_i[33:2];
        op_q <= wr_op;
      end
      if (resp_evt) resp_q <= dmi_resp_data_i;
    end
  assign dmi_req_valid_o = state == ST_REQ;
  assign dmi_resp_ready_o = state == ST_WAIT;
  assign dmi_req_addr_o = addr_q;
  assign dmi_req_data_o = data_q;
  assign dmi_req_op_o = op_q;
  assign op_out = state != ST_IDLE ? DMI_BUSY : sticky;
  assign dtmcs = {14'b0, 2'b00, 1'b0, IDLE_HINT, sticky, ABITS6, DTM_VERSION};
  assign cust_rg_dat_o = cust_rg_addr_i ? DR_WIDTH'({addr_q, resp_q, op_out}) : DR_WIDTH'(dtmcs);
endmodule

// File: tb/tb_jtag_dtm_ctrl.sv
// tb_jtag_dtm_ctrl: directed self-checking bench for jtag_dtm_ctrl
module tb_jtag_dtm_ctrl;
  logic tck = 1'b0;
  logic trst_n;
  logic cust_rg_addr_i, cust_rg_val_i, cust_rg_dat_re_i, cust_rg_dat_we_i;
  logic [40:0] cust_rg_dat_i, cust_rg_dat_o;
  logic dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o, dmi_hard_reset_o;
  logic [6:0] dmi_req_addr_o;
  logic [31:0] dmi_req_data_o, dmi_resp_data_i;
  logic [1:0] dmi_req_op_o, dmi_resp_op_i;
  int passed = 0;
  int total = 0;
  logic [40:0] v;

  always #5 tck = ~tck;

  jtag_dtm_ctrl dut (
    .tck_i(tck), .trst_n_i(trst_n),
    .cust_rg_addr_i(cust_rg_addr_i), .cust_rg_val_i(cust_rg_val_i),
    .cust_rg_dat_i(cust_rg_dat_i), .cust_rg_dat_o(cust_rg_dat_o),
    .cust_rg_dat_re_i(cust_rg_dat_re_i), .cust_rg_dat_we_i(cust_rg_dat_we_i),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_op_i(dmi_resp_op_i),
    .dmi_hard_reset_o(dmi_hard_reset_o)
  );

  function automatic logic [40:0] dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] o);
    return {a, d, o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic dr_write(input logic a, input logic [40:0] d);
    cust_rg_addr_i = a; cust_rg_val_i = 1'b1; cust_rg_dat_we_i = 1'b1; cust_rg_dat_i = d;
    @(negedge tck);
    cust_rg_val_i = 1'b0; cust_rg_dat_we_i = 1'b0; cust_rg_dat_i = '0;
  endtask

  task automatic capture(input logic a, output logic [40:0] r);
    cust_rg_addr_i = a; cust_rg_val_i = 1'b1; cust_rg_dat_re_i = 1'b1;
    #1 r = cust_rg_dat_o;
    @(negedge tck);
    cust_rg_val_i = 1'b0; cust_rg_dat_re_i = 1'b0;
  endtask

  task automatic peek(input logic a, output logic [40:0] r);
    cust_rg_addr_i = a;
    #1 r = cust_rg_dat_o;
  endtask

  task automatic grant;
    dmi_req_ready_i = 1'b1;
    @(negedge tck);
    dmi_req_ready_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] o);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = d; dmi_resp_op_i = o;
    @(negedge tck);
    dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0; dmi_resp_op_i = '0;
  endtask

  initial begin
    trst_n = 1'b0;
    cust_rg_addr_i = 1'b0; cust_rg_val_i = 1'b0; cust_rg_dat_re_i = 1'b0; cust_rg_dat_we_i = 1'b0;
    cust_rg_dat_i = '0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i = '0; dmi_resp_op_i = '0;
    repeat (2) @(negedge tck);
    chk("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    chk("rst_hard_reset", 64'(dmi_hard_reset_o), 64'd0);
    peek(1'b0, v); chk("rst_dtmcs", 64'(v), 64'h1071);
    peek(1'b1, v); chk("rst_dmi", 64'(v), 64'd0);
    trst_n = 1'b1;
    @(negedge tck);
    dr_write(1'b1, dmi(7'h10, 32'hDEADBEEF, 2'd2));
    chk("wr_req_valid", 64'(dmi_req_valid_o), 64'd1);
    chk("wr_req_addr", 64'(dmi_req_addr_o), 64'h10);
    chk("wr_req_data", 64'(dmi_req_data_o), 64'hDEADBEEF);
    chk("wr_req_op", 64'(dmi_req_op_o), 64'd2);
    chk("wr_resp_ready_in_req", 64'(dmi_resp_ready_o), 64'd0);
    @(negedge tck);
    chk("wr_req_hold", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
        64'({1'b1, 7'h10, 32'hDEADBEEF, 2'd2}));
    grant;
    chk("wait_req_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("wait_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
    respond(32'h0, 2'd0);
    chk("idle_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    peek(1'b0, v); chk("ok_dtmcs", 64'(v), 64'h1071);
    dr_write(1'b1, dmi(7'h11, 32'h0, 2'd1));
    chk("rd_req_op", 64'({dmi_req_valid_o, dmi_req_op_o}), 64'({1'b1, 2'd1}));
    grant;
    respond(32'h12345678, 2'd0);
    capture(1'b1, v); chk("rd_capture", 64'(v), 64'(dmi(7'h11, 32'h12345678, 2'd0)));
    dr_write(1'b1, dmi(7'h12, 32'h1, 2'd0));
    chk("nop_ignored", 64'(dmi_req_valid_o), 64'd0);
    dr_write(1'b1, dmi(7'h12, 32'h1, 2'd3));
    chk("op3_ignored", 64'(dmi_req_valid_o), 64'd0);
    cust_rg_addr_i = 1'b1; cust_rg_val_i = 1'b0; cust_rg_dat_we_i = 1'b1;
    cust_rg_dat_i = dmi(7'h12, 32'h1, 2'd2);
    @(negedge tck);
    cust_rg_dat_we_i = 1'b0; cust_rg_dat_i = '0;
    chk("val0_ignored", 64'(dmi_req_valid_o), 64'd0);
    dr_write(1'b1, dmi(7'h13, 32'hAAAA5555, 2'd2));
    grant;
    capture(1'b1, v); chk("busy_capture", 64'(v), 64'(dmi(7'h13, 32'h12345678, 2'd3)));
    peek(1'b0, v); chk("busy_dtmcs", 64'(v), 64'h1C71);
    respond(32'h0, 2'd0);
    dr_write(1'b1, dmi(7'h14, 32'h1, 2'd2));
    chk("sticky_busy_blocks", 64'(dmi_req_valid_o), 64'd0);
    dr_write(1'b0, 41'h0001_0000);
    peek(1'b0, v); chk("dmireset_dtmcs", 64'(v), 64'h1071);
    dr_write(1'b1, dmi(7'h15, 32'h2, 2'd1));
    chk("after_reset_accept", 64'({dmi_req_valid_o, dmi_req_addr_o}), 64'({1'b1, 7'h15}));
    grant;
    respond(32'hCAFE0001, 2'd2);
    peek(1'b0, v); chk("fail_dtmcs", 64'(v), 64'h1871);
    dr_write(1'b1, dmi(7'h16, 32'h3, 2'd1));
    chk("sticky_fail_blocks", 64'(dmi_req_valid_o), 64'd0);
    dr_write(1'b0, 41'h0001_0000);
    dr_write(1'b1, dmi(7'h17, 32'h4, 2'd1));
    dr_write(1'b1, dmi(7'h18, 32'h5, 2'd2));
    chk("busy_write_ignored", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o}),
        64'({1'b1, 7'h17, 32'h4}));
    peek(1'b0, v); chk("busy_write_sticky", 64'(v), 64'h1C71);
    dr_write(1'b0, 41'h0001_0000);
    dr_write(1'b1, dmi(7'h19, 32'h6, 2'd2));
    grant;
    dmi_resp_valid_i = 1'b1; dmi_resp_op_i = 2'd2;
    cust_rg_addr_i = 1'b0; cust_rg_val_i = 1'b1; cust_rg_dat_we_i = 1'b1; cust_rg_dat_i = 41'h0001_0000;
    @(negedge tck);
    dmi_resp_valid_i = 1'b0; dmi_resp_op_i = 2'd0;
    cust_rg_val_i = 1'b0; cust_rg_dat_we_i = 1'b0; cust_rg_dat_i = '0;
    chk("clear_wins_idle", 64'(dmi_resp_ready_o), 64'd0);
    peek(1'b0, v); chk("clear_wins_dtmcs", 64'(v), 64'h1071);
    dr_write(1'b1, dmi(7'h1A, 32'h7, 2'd2));
    chk("pre_trst_valid", 64'(dmi_req_valid_o), 64'd1);
    trst_n = 1'b0;
    #1;
    chk("trst_drops_valid", 64'(dmi_req_valid_o), 64'd0);
    peek(1'b0, v); chk("trst_dtmcs", 64'(v), 64'h1071);
    peek(1'b1, v); chk("trst_dmi", 64'(v), 64'd0);
    @(negedge tck);
    trst_n = 1'b1;
    @(negedge tck);
    chk("post_trst_idle", 64'({dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);
    dr_write(1'b1, dmi(7'h1B, 32'h8, 2'd1));
    chk("post_trst_accept", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o}),
        64'({1'b1, 7'h1B, 2'd1}));
    grant;
    capture(1'b1, v);
    dr_write(1'b0, 41'h0002_0000);
`ifdef JTAG_DTM_HARDRESET_EN
    chk("hard_pulse", 64'(dmi_hard_reset_o), 64'd1);
    chk("hard_idle", 64'({dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);
    peek(1'b0, v); chk("hard_clears_sticky", 64'(v), 64'h1071);
    @(negedge tck);
    chk("hard_one_cycle", 64'(dmi_hard_reset_o), 64'd0);
`else
    chk("hard_tied_low", 64'(dmi_hard_reset_o), 64'd0);
    chk("hard_ignored_wait", 64'(dmi_resp_ready_o), 64'd1);
    peek(1'b0, v); chk("hard_ignored_sticky", 64'(v), 64'h1C71);
    respond(32'h0, 2'd0);
    dr_write(1'b0, 41'h0001_0000);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
